// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with branch, stall and watchdog timeout
// Four-state run controller: IDLE/RUN/DONE/TIMEOUT, all outputs registered or state-decoded.
module pc_sequencer #(
  parameter int WIDTH      = 64,
  parameter int WDOG_BITS  = 16,
  parameter int WDOG_LIMIT = 32
) (
  input  logic                 CLK,
  input  logic                 resetl,
  input  logic                 start,
  input  logic [WIDTH-1:0]     startpc,
  input  logic [WIDTH-1:0]     endpc,
  input  logic                 stall,
  input  logic                 uncondbranch,
  input  logic                 branch,
  input  logic                 zero,
  input  logic [WIDTH-1:0]     signextimm,
  output logic [WIDTH-1:0]     currentpc,
  output logic [WDOG_BITS-1:0] cycles,
  output logic                 running,
  output logic                 done,
  output logic                 timeout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_DONE    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  localparam logic [WDOG_BITS-1:0] LIMIT    = WDOG_BITS'(WDOG_LIMIT);
  localparam logic [WDOG_BITS-1:0] LIMIT_M1 = WDOG_BITS'(WDOG_LIMIT - 1);

  state_t               r_state;
  logic [WIDTH-1:0]     r_pc;
  logic [WDOG_BITS-1:0] r_cycles;

  state_t               w_state_nx;
  logic [WIDTH-1:0]     w_pc_nx;
  logic [WDOG_BITS-1:0] w_cycles_nx;
  logic [WIDTH-1:0]     w_offset;
  logic                 w_take;
  logic [WIDTH-1:0]     w_nextpc;

  // Word offset: the two top bits of the immediate fall off the shift.
  assign w_offset = {signextimm[WIDTH-3:0], 2'b00};
  assign w_take   = uncondbranch | (branch & zero);
  assign w_nextpc = r_pc + (w_take ? w_offset : WIDTH'(4));

  always_comb begin
    w_state_nx  = r_state;
    w_pc_nx     = r_pc;
    w_cycles_nx = r_cycles;
    case (r_state)
      S_RUN: begin
        if (r_pc >= endpc) begin
          w_state_nx = S_DONE;
        end else if (r_cycles == LIMIT_M1) begin
          w_state_nx  = S_TIMEOUT;
          w_cycles_nx = LIMIT;
        end else begin
          w_cycles_nx = r_cycles + WDOG_BITS'(1);
          if (!stall) begin
            w_pc_nx = w_nextpc;
          end
        end
      end
      default: begin
        if (start) begin
          w_state_nx  = S_RUN;
          w_pc_nx     = startpc;
          w_cycles_nx = '0;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_cycles <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_pc     <= w_pc_nx;
      r_cycles <= w_cycles_nx;
    end
  end

  assign currentpc = r_pc;
  assign cycles    = r_cycles;
  assign running   = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign timeout   = (r_state == S_TIMEOUT);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
// Directed scenarios followed by random traffic, compared against an arithmetic reference model.
module tb_pc_sequencer;

  localparam int WIDTH = 64;
  localparam int WB    = 16;
  localparam int LIM   = 32;

  logic             CLK = 1'b0;
  logic             resetl;
  logic             start;
  logic [WIDTH-1:0] startpc;
  logic [WIDTH-1:0] endpc;
  logic             stall;
  logic             uncondbranch;
  logic             branch;
  logic             zero;
  logic [WIDTH-1:0] signextimm;
  logic [WIDTH-1:0] currentpc;
  logic [WB-1:0]    cycles;
  logic             running;
  logic             done;
  logic             timeout;

  pc_sequencer #(.WIDTH(WIDTH), .WDOG_BITS(WB), .WDOG_LIMIT(LIM)) dut (
    .CLK(CLK), .resetl(resetl), .start(start), .startpc(startpc), .endpc(endpc),
    .stall(stall), .uncondbranch(uncondbranch), .branch(branch), .zero(zero),
    .signextimm(signextimm), .currentpc(currentpc), .cycles(cycles),
    .running(running), .done(done), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  // Reference: mode 0=idle 1=run 2=done 3=timeout
  int               m_mode;
  logic [WIDTH-1:0] m_pc;
  int               m_cyc;
  int               n_checks = 0;
  int               n_fail   = 0;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc"}, currentpc, m_pc);
    chk({tag, ".cycles"}, WIDTH'(cycles), WIDTH'(m_cyc));
    chk({tag, ".running"}, WIDTH'(running), WIDTH'(m_mode == 1));
    chk({tag, ".done"}, WIDTH'(done), WIDTH'(m_mode == 2));
    chk({tag, ".timeout"}, WIDTH'(timeout), WIDTH'(m_mode == 3));
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc   = '0;
    m_cyc  = 0;
  endtask

  task automatic model_edge();
    if (!resetl) begin
      model_reset();
    end else if (m_mode != 1) begin
      if (start) begin
        m_mode = 1;
        m_pc   = startpc;
        m_cyc  = 0;
      end
    end else if (m_pc >= endpc) begin
      m_mode = 2;
    end else if (m_cyc == LIM - 1) begin
      m_mode = 3;
      m_cyc  = LIM;
    end else begin
      m_cyc = m_cyc + 1;
      if (!stall) begin
        if (uncondbranch || (branch && zero)) m_pc = m_pc + signextimm * 4;
        else                                  m_pc = m_pc + 4;
      end
    end
  endtask

  // Inputs are changed only at +1 after an edge, so they are stable for the model and the DUT.
  task automatic cyc(input string tag);
    model_edge();
    @(posedge CLK);
    #1;
    chk_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #3;
    resetl = 1'b0;
    model_reset();
    #1;
    chk_all(tag);
  endtask

  task automatic quiet();
    start = 0; stall = 0; uncondbranch = 0; branch = 0; zero = 0; signextimm = '0;
  endtask

  initial begin
    resetl = 0; quiet(); start = 1; startpc = 64'h40; endpc = 64'h80;
    model_reset();
    #1;
    chk_all("reset_async");
    cyc("reset_start_ignored");
    cyc("reset_hold");

    // Linear run 0..0x30, then done with cycles=12
    resetl = 1; start = 1; startpc = '0; endpc = 64'h30;
    cyc("lin_launch");
    chk("lin_launch_running", WIDTH'(running), 1);
    start = 0;
    for (int i = 0; i < 12; i++) cyc("lin_step");
    chk("lin_at_end", currentpc, 64'h30);
    cyc("lin_done");
    chk("lin_done_flag", WIDTH'(done), 1);
    chk("lin_done_cycles", WIDTH'(cycles), 12);
    cyc("lin_done_hold");
    cyc("lin_done_hold2");

    // Relaunch from DONE, then branches; start kept high during RUN is ignored
    start = 1; startpc = '0; endpc = 64'h100;
    cyc("relaunch");
    chk("relaunch_cycles", WIDTH'(cycles), 0);
    startpc = 64'h80;
    cyc("start_in_run");
    cyc("to_pc8");
    chk("br_at8", currentpc, 64'h8);
    start = 0; uncondbranch = 1; branch = 1; zero = 0; signextimm = 64'd3;
    cyc("br_uncond");
    chk("br_uncond_pc", currentpc, 64'h14);
    uncondbranch = 0; branch = 1; zero = 0;
    cyc("br_not_taken");
    chk("br_not_taken_pc", currentpc, 64'h18);
    zero = 1; signextimm = -64'sd2;
    cyc("br_taken_neg");
    chk("br_taken_neg_pc", currentpc, 64'h10);
    quiet();
    cyc("pre_reset");

    // Reset pulsed between edges mid-RUN
    async_reset("midrun_reset");
    cyc("midrun_reset_edge");
    #1 resetl = 1;

    // Stall: PC frozen, watchdog fires with cycles=32
    start = 1; startpc = '0; endpc = 64'h30;
    cyc("stall_launch");
    start = 0; stall = 1;
    for (int i = 0; i < LIM - 1; i++) cyc("stall_step");
    chk("stall_cycles31", WIDTH'(cycles), 31);
    chk("stall_pc_frozen", currentpc, 64'h0);
    cyc("stall_timeout");
    chk("stall_timeout_flag", WIDTH'(timeout), 1);
    chk("stall_timeout_cycles", WIDTH'(cycles), 32);
    stall = 0;
    cyc("timeout_hold");

    // Wrap past 2^WIDTH
    start = 1; startpc = -64'sd4; endpc = -64'sd1;
    cyc("wrap_launch");
    start = 0;
    cyc("wrap_step");
    chk("wrap_pc0", currentpc, 64'h0);
    chk("wrap_no_done", WIDTH'(done), 0);
    for (int i = 0; i < LIM; i++) cyc("wrap_run");
    chk("wrap_timeout", WIDTH'(timeout), 1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      int t;
      start        = ($urandom_range(0, 7) == 0);
      startpc      = WIDTH'($urandom_range(0, 16)) * 4;
      endpc        = WIDTH'($urandom_range(0, 160));
      stall        = ($urandom_range(0, 5) == 0);
      uncondbranch = ($urandom_range(0, 6) == 0);
      branch       = $urandom_range(0, 1);
      zero         = $urandom_range(0, 1);
      t            = int'($urandom_range(0, 15)) - 8;
      signextimm   = WIDTH'(t);
      if ($urandom_range(0, 9) == 0) signextimm[WIDTH-1 -: 2] = ~signextimm[WIDTH-1 -: 2];
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rnd_areset");
      end else begin
        resetl = 1'b1;
      end
      cyc("rnd");
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 64, PC and offset width in bits.
REQ-002 Parameter WDOG_BITS, default 16, cycle-counter width.
REQ-003 Parameter WDOG_LIMIT, default 32, RUN cycles allowed before timeout; legal range 1..2^WDOG_BITS-1.
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 resetl  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  launch/relaunch request; sampled at the rising edge.
REQ-007 startpc  input  WIDTH  PC loaded on an accepted start.
REQ-008 endpc  input  WIDTH  program end; execution completes once currentpc >= endpc (unsigned).
REQ-009 stall  input  1  hold PC this cycle; the cycle counter still advances.
REQ-010 uncondbranch  input  1  unconditional branch taken this cycle.
REQ-011 branch  input  1  conditional branch (CBZ-type) this cycle.
REQ-012 zero  input  1  ALU zero flag qualifying branch.
REQ-013 signextimm  input  WIDTH  sign-extended word offset.
REQ-014 currentpc  output  WIDTH  registered program counter.
REQ-015 cycles  output  WDOG_BITS  registered RUN-cycle count.
REQ-016 running  output  1  high in state RUN.
REQ-017 done  output  1  high in state DONE.
REQ-018 timeout  output  1  high in state TIMEOUT.

Function
REQ-019 The block SHALL implement the four states IDLE, RUN, DONE and TIMEOUT, and all outputs SHALL be registered or decoded from state only.
REQ-020 In IDLE, DONE or TIMEOUT with start=1, the block SHALL load currentpc<=startpc, load cycles<=0 and enter RUN on the same edge.
REQ-021 In IDLE, DONE or TIMEOUT with start=0, the block SHALL hold currentpc, cycles and state.
REQ-022 In RUN, start SHALL be ignored.
REQ-023 In RUN, the block SHALL check in priority order at each edge: (a) currentpc >= endpc -> DONE, PC and cycles held; (b) else cycles == WDOG_LIMIT-1 -> TIMEOUT, cycles<=WDOG_LIMIT, PC held; (c) else cycles<=cycles+1, and PC updates per REQ-024 when stall=0 or holds when stall=1.
REQ-024 nextpc SHALL be currentpc + (signextimm<<2) when uncondbranch=1, else when branch=1 and zero=1; otherwise nextpc SHALL be currentpc + 4.
REQ-025 uncondbranch SHALL take priority over branch.
REQ-026 nextpc arithmetic SHALL be modulo 2^WIDTH, with a negative offset wrapping silently and no flag raised.
REQ-027 The signextimm<<2 shift SHALL discard the top two bits.
REQ-028 When the done and timeout conditions coincide, done SHALL win.
REQ-029 The endpc comparison SHALL be unsigned, against the registered currentpc, using the live endpc input.
REQ-030 The block SHALL have a latency of one edge from start to running=1 with currentpc=startpc.
REQ-031 The block SHALL have a latency of one edge from currentpc reaching endpc to done=1.

Reset
REQ-032 On resetl=0, regardless of CLK, the block SHALL immediately force state=IDLE, currentpc=0, cycles=0, running=0, done=0 and timeout=0.
REQ-033 Reset asserted mid-RUN SHALL abort execution with no completion flag.
REQ-034 After resetl rises, the first edge SHALL act as IDLE.
REQ-035 A start coincident with resetl=0 SHALL be ignored.

Verification
REQ-036 Linear run: startpc=0, endpc=0x30, no branches, start pulse -> PC 0,4,...,0x30, then done=1 at the next edge with cycles=12, and done holds.
REQ-037 Branches: at PC=0x8, uncondbranch=1 with signextimm=3 -> PC=0x14; at PC=0x14, branch=1, zero=0 -> PC=0x18; then branch=1, zero=1, signextimm=-2 -> PC=0x10.
REQ-038 Stall and watchdog: WDOG_LIMIT=32, stall held high, endpc=0x30 -> PC frozen at startpc, cycles counts 0..31, timeout=1 with cycles=32 on the following edge.
REQ-039 Wrap: startpc=2^WIDTH-4, endpc=2^WIDTH-1 -> next PC=0, no done, run continues until timeout.
REQ-040 Relaunch and reset: start during RUN has no effect; start in DONE -> RUN with cycles=0 and currentpc=startpc; resetl pulsed low mid-RUN between edges -> immediate IDLE with currentpc=0 and all flags 0.
